muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the M-extension ALU ops: ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM and ALU_REMU.
- Sits beside the single-cycle ALU in EX. It runs a radix-2 shift-add multiplier or a restoring divider over WIDTH iterations.
- It holds the pipeline via stall_o until the result is ready.
- Opcode encodings come from all_pkgs.

---
 rtl/muldiv_seq.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_seq                                                   |
// | Description : Multi-cycle M-extension sequencer (MUL/MULH/MULHSU/MULHU,    |
// |               REM/REMU). Radix-2 shift-add multiply, restoring divide.     |
// |               Optional build macro MULDIV_EARLY_OUT_EN adds zero-operand   |
// |               and REMU small-dividend short-cuts.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [4:0]       alu_op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam logic [4:0] c_ALU_MUL    = 5'b00110;
    localparam logic [4:0] c_ALU_MULH   = 5'b00111;
    localparam logic [4:0] c_ALU_MULHSU = 5'b01000;
    localparam logic [4:0] c_ALU_MULHU  = 5'b01001;
    localparam logic [4:0] c_ALU_REM    = 5'b01010;
    localparam logic [4:0] c_ALU_REMU   = 5'b01011;

    localparam logic [WIDTH-1:0]   c_ONE    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_ONE2   = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   c_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   c_CNT_1  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [4:0]           r_op;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_result;

    logic                 w_is_md;
    logic                 w_accept;
    logic                 w_in_rem;
    logic                 w_div0;
    logic                 w_early;
    logic                 w_short;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_r_is_rem;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_trial;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_borrow;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_fin_res;

    assign w_is_md  = (alu_op_i >= c_ALU_MUL) && (alu_op_i <= c_ALU_REMU);
    assign w_accept = start_i && w_is_md && !flush_i;
    assign w_in_rem = (alu_op_i == c_ALU_REM) || (alu_op_i == c_ALU_REMU);
    assign w_div0   = w_in_rem && (rs2_i == '0);

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early  = (!w_in_rem && ((rs1_i == '0) || (rs2_i == '0)))
                   || ((alu_op_i == c_ALU_REMU) && (rs1_i < rs2_i));
`else
    assign w_early  = 1'b0;
`endif
    assign w_short  = w_div0 || w_early;

    assign w_sa = rs1_i[WIDTH-1] && ((alu_op_i == c_ALU_MULH) || (alu_op_i == c_ALU_MULHSU)
                                  || (alu_op_i == c_ALU_REM));
    assign w_sb = rs2_i[WIDTH-1] && ((alu_op_i == c_ALU_MULH) || (alu_op_i == c_ALU_REM));
    assign w_mag_a = w_sa ? (~rs1_i + c_ONE) : rs1_i;
    assign w_mag_b = w_sb ? (~rs2_i + c_ONE) : rs2_i;

    // Divide keeps the dividend in the low half of r_acc and the divisor in r_opnd.
    assign w_r_is_rem   = (r_op == c_ALU_REM) || (r_op == c_ALU_REMU);
    assign w_mul_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    assign w_div_trial  = {r_rem, r_acc[WIDTH-1]};
    assign w_div_diff   = w_div_trial - {1'b0, r_opnd};
    // Trial can exceed WIDTH bits only when it is already above the divisor.
    assign w_div_borrow = !w_div_trial[WIDTH] && w_div_diff[WIDTH];

    assign w_prod    = r_neg ? (~r_acc + c_ONE2) : r_acc;
    assign w_fin_res = w_r_is_rem      ? (r_neg ? (~r_rem + c_ONE) : r_rem) :
                       (r_op == c_ALU_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall_o      = 1'b1;
                    w_next_state = w_short ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                stall_o = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN: begin
                stall_o      = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                done_o       = !flush_i;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (flush_i) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= alu_op_i;
                        r_neg  <= w_in_rem ? w_sa : (w_sa ^ w_sb);
                        r_cnt  <= '0;
                        r_rem  <= '0;
                        r_acc  <= {{WIDTH{1'b0}}, (w_in_rem ? w_mag_a : w_mag_b)};
                        r_opnd <= w_in_rem ? w_mag_b : w_mag_a;
                        // Short-cut results: remainder passes rs1 through, multiply gives 0.
                        if (w_short) begin
                            r_result <= w_in_rem ? rs1_i : '0;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + c_CNT_1;
                    if (w_r_is_rem) begin
                        r_rem <= w_div_borrow ? w_div_trial[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
                        r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                end
                S_FIN: begin
                    if (!flush_i) begin
                        r_result <= w_fin_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;
    assign busy_o   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// Directed bench for muldiv_seq: vector table plus flush/reset/non-M-op sequences.
module tb_muldiv_seq;

    localparam logic [4:0] ADD    = 5'b00000;
    localparam logic [4:0] MUL    = 5'b00110;
    localparam logic [4:0] MULH   = 5'b00111;
    localparam logic [4:0] MULHSU = 5'b01000;
    localparam logic [4:0] MULHU  = 5'b01001;
    localparam logic [4:0] REM    = 5'b01010;
    localparam logic [4:0] REMU   = 5'b01011;
    localparam int         NV     = 22;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [4:0]  alu_op_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .alu_op_i (alu_op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if ((op == REM || op == REMU) && b == 32'd0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (op >= MUL && op <= MULHU && (a == 32'd0 || b == 32'd0)) return 1;
        if (op == REMU && a < b) return 1;
`endif
        return 34;
    endfunction

    // Issue one op for a single cycle and wait (bounded) for done_o.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic st, output int lat, output logic [31:0] res,
                         output logic st_done);
        @(negedge clk);
        alu_op_i = op;
        rs1_i    = a;
        rs2_i    = b;
        start_i  = 1'b1;
        #1 st    = stall_o;
        lat      = 0;
        res      = 32'hDEAD_BEEF;
        st_done  = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
            if (done_o) begin
                lat     = n;
                res     = result_o;
                st_done = stall_o;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        st, st_done;
        int          lat, ndone;
        logic [31:0] res, prev;

        vecs[0]  = '{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{MUL,    32'd6,         32'd7,         32'd42};
        vecs[2]  = '{MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[3]  = '{MUL,    32'd0,         32'h0000_007B, 32'h0000_0000};
        vecs[4]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[5]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6]  = '{MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
        vecs[7]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[8]  = '{MULHU,  32'h8000_0000, 32'd4,         32'h0000_0002};
        vecs[9]  = '{MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
        vecs[10] = '{MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        vecs[11] = '{MULHSU, 32'd2,         32'hFFFF_FFFF, 32'h0000_0001};
        vecs[12] = '{REM,    32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF};
        vecs[13] = '{REM,    32'd7,         32'hFFFF_FFFD, 32'h0000_0001};
        vecs[14] = '{REM,    32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE};
        vecs[15] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[16] = '{REMU,   32'd100,       32'd7,         32'd2};
        vecs[17] = '{REMU,   32'hFFFF_FFFF, 32'd16,        32'd15};
        vecs[18] = '{REMU,   32'd5,         32'd7,         32'd5};
        vecs[19] = '{REMU,   32'd5,         32'd0,         32'd5};
        vecs[20] = '{REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        vecs[21] = '{MUL,    32'h0001_2345, 32'h10,        32'h0012_3450};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",  {31'd0, stall_o}, 32'd0);
        chk("rst_done",   {31'd0, done_o},  32'd0);
        chk("rst_busy",   {31'd0, busy_o},  32'd0);
        chk("rst_result", result_o,         32'd0);
        rst_n = 1'b1;

        // Non-M op is ignored
        @(negedge clk);
        alu_op_i = ADD;
        rs1_i    = 32'd9;
        rs2_i    = 32'd4;
        start_i  = 1'b1;
        #1 chk("add_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("add_busy", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, st, lat, res, st_done);
            chk($sformatf("v%0d_stall_start", i), {31'd0, st}, 32'd1);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].op, vecs[i].a, vecs[i].b)));
            chk($sformatf("v%0d_result", i), res, vecs[i].r);
            chk($sformatf("v%0d_stall_done", i), {31'd0, st_done}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done_o}, 32'd0);
            chk($sformatf("v%0d_idle", i), {31'd0, busy_o}, 32'd0);
        end
        prev = vecs[NV-1].r;

        // Flush in the middle of BUSY
        @(negedge clk);
        alu_op_i = MUL;
        rs1_i    = 32'd11;
        rs2_i    = 32'd13;
        start_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("flush_pre_busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_busy",   {31'd0, busy_o}, 32'd0);
        chk("flush_stall",  {31'd0, stall_o}, 32'd0);
        chk("flush_result", result_o, prev);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        chk("flush_no_done", 32'(ndone), 32'd0);
        chk("flush_result_hold", result_o, prev);

        // Asynchronous reset mid-operation
        @(negedge clk);
        alu_op_i = MUL;
        rs1_i    = 32'd3;
        rs2_i    = 32'd5;
        start_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_rst_busy",   {31'd0, busy_o},  32'd0);
        chk("amid_rst_stall",  {31'd0, stall_o}, 32'd0);
        chk("amid_rst_done",   {31'd0, done_o},  32'd0);
        chk("amid_rst_result", result_o,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal operation after reset
        issue(REMU, 32'd100, 32'd7, st, lat, res, st_done);
        chk("post_rst_latency", 32'(lat), 32'd34);
        chk("post_rst_result",  res,      32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
